// File: rtl/fp2int_converter_if.sv
// Handshake bundle for the float32 -> int32 converter.
// The slave side is the converter; the master side feeds operands and takes results.
interface fp2int_converter_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp2int_converter.sv
// Iterative float32 -> signed int32 converter, one shift bit per cycle.
// Define F2I_RTZ_EN for round-toward-zero instead of round-to-nearest-even.
module fp2int_converter (
    input  logic               clk,
    input  logic               rst,
    fp2int_converter_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_SHIFT,
        S_ROUND,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [31:0] r_op;
    logic [31:0] r_acc;
    logic        r_guard;
    logic        r_sticky;
    logic        r_left;
    logic [7:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [1:0]  r_out_flags;

    logic        w_sign;
    logic [7:0]  w_exp;
    logic [22:0] w_man;
    logic [31:0] w_m;
    logic        w_nan;
    logic        w_inf;
    logic        w_zero;
    logic        w_den;
    logic        w_big;
    logic        w_left;
    logic [7:0]  w_n;
    logic        w_special;
    logic [31:0] w_sp_data;
    logic [1:0]  w_sp_flags;
    logic        w_inc;
    logic [31:0] w_mag;
    logic [31:0] w_res;

    assign w_sign = r_op[31];
    assign w_exp  = r_op[30:23];
    assign w_man  = r_op[22:0];
    assign w_m    = {8'd0, 1'b1, w_man};

    assign w_nan  = (w_exp == 8'hFF) && (w_man != 23'd0);
    assign w_inf  = (w_exp == 8'hFF) && (w_man == 23'd0);
    assign w_zero = (w_exp == 8'h00) && (w_man == 23'd0);
    assign w_den  = (w_exp == 8'h00) && (w_man != 23'd0);
    assign w_big  = (w_exp >= 8'd158) && (w_exp != 8'hFF);
    assign w_left = (w_exp >= 8'd150);

    assign w_special = w_nan | w_inf | w_zero | w_den | w_big;

    // Right shifts beyond 25 only feed sticky, so cap the count there.
    always_comb begin
        w_n = 8'd0;
        if (w_left)
            w_n = w_exp - 8'd150;
        else if (w_exp < 8'd125)
            w_n = 8'd25;
        else
            w_n = 8'd150 - w_exp;
    end

    always_comb begin
        w_sp_data  = 32'd0;
        w_sp_flags = 2'b00;
        unique case (1'b1)
            w_nan: begin
                w_sp_data  = 32'h8000_0000;
                w_sp_flags = 2'b10;
            end
            w_inf: begin
                w_sp_data  = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                w_sp_flags = 2'b10;
            end
            w_zero: begin
                w_sp_data  = 32'd0;
                w_sp_flags = 2'b00;
            end
            w_den: begin
                w_sp_data  = 32'd0;
                w_sp_flags = 2'b01;
            end
            w_big: begin
                if (r_op == 32'hCF00_0000) begin
                    w_sp_data  = 32'h8000_0000;
                    w_sp_flags = 2'b00;
                end else begin
                    w_sp_data  = w_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    w_sp_flags = 2'b10;
                end
            end
            default: begin
                w_sp_data  = 32'd0;
                w_sp_flags = 2'b00;
            end
        endcase
    end

`ifdef F2I_RTZ_EN
    assign w_inc = 1'b0;
`else
    assign w_inc = r_guard & (r_sticky | r_acc[0]);
`endif

    assign w_mag = r_acc + {31'd0, w_inc};
    assign w_res = w_sign ? (~w_mag + 32'd1) : w_mag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_op        <= 32'd0;
            r_acc       <= 32'd0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_left      <= 1'b0;
            r_cnt       <= 8'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'd0;
            r_out_flags <= 2'b00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_op       <= bus.in_data;
                        r_in_ready <= 1'b0;
                        r_state    <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (w_special) begin
                        r_out_data  <= w_sp_data;
                        r_out_flags <= w_sp_flags;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_acc    <= w_m;
                        r_guard  <= 1'b0;
                        r_sticky <= 1'b0;
                        r_left   <= w_left;
                        r_cnt    <= w_n;
                        r_state  <= (w_n == 8'd0) ? S_ROUND : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_left) begin
                        r_acc <= {r_acc[30:0], 1'b0};
                    end else begin
                        r_acc    <= {1'b0, r_acc[31:1]};
                        r_guard  <= r_acc[0];
                        r_sticky <= r_sticky | r_guard;
                    end
                    r_cnt <= r_cnt - 8'd1;
                    if (r_cnt == 8'd1)
                        r_state <= S_ROUND;
                end
                S_ROUND: begin
                    r_out_data  <= w_res;
                    r_out_flags <= {1'b0, r_guard | r_sticky};
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_flags = r_out_flags;

endmodule

// File: tb/tb_fp2int_converter.sv
// Bench for fp2int_converter: arithmetic reference model plus directed vectors.
// Checks results, flags, latency, back-pressure hold and mid-operation reset.
module tb_fp2int_converter;
    logic clk = 1'b0;
    logic rst = 1'b0;

    fp2int_converter_if bus();

    fp2int_converter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Reference: value = 1.mant * 2^(e-150), rounded from exact integer remainder.
    function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                  output logic [1:0] f, output int lat);
        int     e;
        int     sh;
        int     sa;
        bit     s;
        longint m;
        longint q;
        longint rem;
        longint half;
        s   = x[31];
        e   = int'(x[30:23]);
        m   = longint'({1'b1, x[22:0]});
        lat = 1;
        f   = 2'b00;
        r   = 32'd0;
        if (e == 255) begin
            f = 2'b10;
            r = (s || x[22:0] != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (e == 0) begin
            f = {1'b0, x[22:0] != 0};
        end else if (e >= 158) begin
            if (x == 32'hCF00_0000) begin
                r = 32'h8000_0000;
            end else begin
                f = 2'b10;
                r = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            if (e >= 150) begin
                q   = m << (e - 150);
                rem = 0;
                lat = e - 150 + 2;
            end else begin
                sh   = 150 - e;
                lat  = (sh > 25 ? 25 : sh) + 2;
                sa   = sh > 40 ? 40 : sh;
                q    = m >> sa;
                rem  = m - (q << sa);
                half = longint'(1) << (sa - 1);
`ifndef F2I_RTZ_EN
                if (rem > half || (rem == half && q[0])) q++;
`endif
            end
            f = {1'b0, rem != 0};
            r = s ? 32'(-q) : 32'(q);
        end
    endfunction

    // Compare process: tracks the outstanding transaction against the model.
    bit          pend = 1'b0;
    bit          seen = 1'b0;
    bit          rel  = 1'b0;
    int          edges = 0;
    logic [31:0] ed;
    logic [1:0]  ef;
    int          el;

    always @(posedge clk) begin
        bit acc;
        bit done;
        acc  = rst && bus.in_valid && bus.in_ready;
        done = rst && bus.out_valid && bus.out_ready;
        if (!rst) pend = 1'b0;
        if (pend) edges++;
        if (done) pend = 1'b0;
        rel = done;
        if (acc) begin
            model(bus.in_data, ed, ef, el);
            pend  = 1'b1;
            seen  = 1'b0;
            edges = 0;
        end
        #1;
        if (rel) chk("in_ready_after_accept", {31'd0, bus.in_ready}, 32'd1);
        if (bus.out_valid) begin
            if (!pend) begin
                chk("spurious_valid", {31'd0, bus.out_valid}, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(edges), 32'(el));
                    seen = 1'b1;
                end
                chk("out_data", bus.out_data, ed);
                chk("out_flags", {30'd0, bus.out_flags}, {30'd0, ef});
                chk("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
            end
        end else if (pend) begin
            chk("in_ready_busy", {31'd0, bus.in_ready}, 32'd0);
            if (edges > 40) begin
                chk("timeout", 32'(edges), 32'(el));
                pend = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] x, input int hold);
        int n;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.in_data   = x;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        n = 0;
        while (!bus.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.out_valid)
            chk("send_timeout", {31'd0, bus.out_valid}, 32'd1);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        logic [1:0]  f;
        int          lat;
    } pin_t;

`ifdef F2I_RTZ_EN
    localparam logic [31:0] R15 = 32'd1;
`else
    localparam logic [31:0] R15 = 32'd2;
`endif

    pin_t pins [0:13] = '{
        '{32'h4049_0FDB, 32'd3,          2'b01, 24},
        '{32'h3F00_0000, 32'd0,          2'b01, 26},
        '{32'h3FC0_0000, R15,            2'b01, 25},
        '{32'h4020_0000, 32'd2,          2'b01, 24},
        '{32'hC020_0000, 32'hFFFF_FFFE,  2'b01, 24},
        '{32'h4B80_0001, 32'd16777218,   2'b00, 3},
        '{32'hCF00_0000, 32'h8000_0000,  2'b00, 1},
        '{32'h4F00_0000, 32'h7FFF_FFFF,  2'b10, 1},
        '{32'h4EFF_FFFF, 32'd2147483520, 2'b00, 9},
        '{32'h7FC0_0000, 32'h8000_0000,  2'b10, 1},
        '{32'hFF80_0000, 32'h8000_0000,  2'b10, 1},
        '{32'h0000_0001, 32'd0,          2'b01, 1},
        '{32'h8000_0000, 32'd0,          2'b00, 1},
        '{32'h4120_0000, 32'd10,         2'b00, 22}
    };

    logic [31:0] extra [0:5] = '{
        32'h7F80_0000, 32'hC2F6_E979, 32'h3F7F_FFFF,
        32'h4B7F_FFFF, 32'h3E80_0000, 32'h3300_0000
    };

    initial begin
        logic [31:0] r;
        logic [1:0]  f;
        int          l;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.out_ready = 1'b1;

        foreach (pins[i]) begin
            model(pins[i].x, r, f, l);
            chk("pin_data", r, pins[i].r);
            chk("pin_flags", {30'd0, f}, {30'd0, pins[i].f});
            chk("pin_lat", 32'(l), 32'(pins[i].lat));
        end

        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_flags", {30'd0, bus.out_flags}, 32'd0);
        rst = 1'b1;

        foreach (pins[i]) send(pins[i].x, 0);
        foreach (extra[i]) send(extra[i], 0);

        send(32'h4020_0000, 5);

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F80_0001;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_out_data", bus.out_data, 32'd0);
        chk("arst_out_flags", {30'd0, bus.out_flags}, 32'd0);
        chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (35) @(negedge clk);

        send(32'h4120_0000, 0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
